// File: rtl/icap_pkg.sv
// Shared constants, request payload, state encoding and bit-order helpers
// for the ICAP warm-reboot sequencer.
package icap_pkg;

  localparam logic [15:0] DUMMY_WORD   = 16'hFFFF;
  localparam logic [15:0] SYNC_HI      = 16'hAA99;
  localparam logic [15:0] SYNC_LO      = 16'h5566;
  localparam logic [15:0] HDR_GENERAL1 = 16'h3261;
  localparam logic [15:0] HDR_GENERAL2 = 16'h3281;
  localparam logic [15:0] HDR_GENERAL3 = 16'h32A1;
  localparam logic [15:0] HDR_GENERAL4 = 16'h32C1;
  localparam logic [15:0] HDR_CMD      = 16'h30A1;
  localparam logic [15:0] CMD_IPROG    = 16'h000E;
  localparam logic [15:0] NOOP_WORD    = 16'h2000;

  // Words between the dummy preamble and the NOOP tail (sync .. IPROG).
  localparam int unsigned FIXED_WORDS = 12;

  typedef struct packed {
    logic [23:0] boot_addr;
    logic [23:0] fallback_addr;
    logic [7:0]  read_opcode;
  } boot_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_STROBE,
    ST_FINISH
  } state_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // ICAP expects each byte bit-reversed, byte order unchanged.
  function automatic logic [15:0] icap_swap(input logic [15:0] w);
    return {bitrev8(w[15:8]), bitrev8(w[7:0])};
  endfunction

endpackage

// File: rtl/icap_reboot_seq_if.sv
// Port bundle between the reboot sequencer and the ICAP_SPARTAN6 primitive.
interface icap_reboot_seq_if;
  logic        icap_clk;
  logic        icap_ce_n;
  logic        icap_write_n;
  logic [15:0] icap_i;
  logic        icap_busy;

  modport master (
    output icap_clk, icap_ce_n, icap_write_n, icap_i,
    input  icap_busy
  );

  modport slave (
    input  icap_clk, icap_ce_n, icap_write_n, icap_i,
    output icap_busy
  );
endinterface

// File: rtl/icap_clk_div.sv
// Half-period counter for the divided ICAP clock; ticks on the last system
// cycle of every DIV-cycle phase while run is high.
module icap_clk_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic phase_end_c
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_end_c = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (!run || cnt == LAST) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/icap_reboot_seq.sv
// Streams the IPROG warm-reboot packet sequence into the ICAP with a divided,
// registered ICAP clock; words rejected by ICAP BUSY are re-sent.
module icap_reboot_seq
  import icap_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned DUMMY_WORDS = 6,
  parameter int unsigned NOOP_TAIL   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [23:0]        boot_addr,
  input  logic [23:0]        fallback_addr,
  input  logic [7:0]         read_opcode,
  output logic               busy,
  output logic               done,
  icap_reboot_seq_if.master  icap
);

  localparam int unsigned   N          = DUMMY_WORDS + FIXED_WORDS + NOOP_TAIL;
  localparam int unsigned   IW         = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
  localparam logic [IW-1:0] FIXED_BASE = IW'(DUMMY_WORDS);
  localparam logic [IW-1:0] TAIL_BASE  = IW'(DUMMY_WORDS + FIXED_WORDS);

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          busy_smp, busy_smp_n;
  boot_req_t     req;
  logic          accept_c;
  logic          run_c;
  logic          phase_end_c;
  logic          drive_c;
  logic [3:0]    fix_off_c;
  logic [15:0]   word_c;

  // A start coinciding with the done pulse is dropped.
  assign accept_c = (state == ST_IDLE) && start && !done;
  assign run_c    = (state == ST_SETUP) || (state == ST_STROBE);

  icap_clk_div #(.DIV(CLK_DIV)) u_clk_div (
    .clk,
    .rst,
    .run        (run_c),
    .phase_end_c
  );

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    busy_smp_n = busy_smp;
    case (state)
      ST_IDLE:   if (accept_c) state_n = ST_LOAD;
      ST_LOAD: begin
        idx_n   = '0;
        state_n = ST_SETUP;
      end
      ST_SETUP: begin
        // icap_clk rises on this edge, so BUSY is captured alongside it
        if (phase_end_c) begin
          busy_smp_n = icap.icap_busy;
          state_n    = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (phase_end_c) begin
          if (busy_smp)             state_n = ST_SETUP;
          else if (idx == LAST_IDX) state_n = ST_FINISH;
          else begin
            idx_n   = IW'(idx + IW'(1));
            state_n = ST_SETUP;
          end
        end
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Logical word for the index that the upcoming SETUP/STROBE will present.
  assign fix_off_c = 4'(idx_n - FIXED_BASE);

  always_comb begin
    word_c = NOOP_WORD;
    if (idx_n < FIXED_BASE) begin
      word_c = DUMMY_WORD;
    end else if (idx_n < TAIL_BASE) begin
      case (fix_off_c)
        4'd0:    word_c = SYNC_HI;
        4'd1:    word_c = SYNC_LO;
        4'd2:    word_c = HDR_GENERAL1;
        4'd3:    word_c = req.boot_addr[15:0];
        4'd4:    word_c = HDR_GENERAL2;
        4'd5:    word_c = {req.read_opcode, req.boot_addr[23:16]};
        4'd6:    word_c = HDR_GENERAL3;
        4'd7:    word_c = req.fallback_addr[15:0];
        4'd8:    word_c = HDR_GENERAL4;
        4'd9:    word_c = {req.read_opcode, req.fallback_addr[23:16]};
        4'd10:   word_c = HDR_CMD;
        4'd11:   word_c = CMD_IPROG;
        default: word_c = NOOP_WORD;
      endcase
    end
  end

  assign drive_c = (state_n == ST_SETUP) || (state_n == ST_STROBE);

  // Outputs follow the next state so pins line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      idx               <= '0;
      busy_smp          <= 1'b0;
      req               <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      icap.icap_clk     <= 1'b0;
      icap.icap_ce_n    <= 1'b1;
      icap.icap_write_n <= 1'b1;
      icap.icap_i       <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      busy_smp <= busy_smp_n;
      if (accept_c) req <= {boot_addr, fallback_addr, read_opcode};
      busy              <= (state_n != ST_IDLE);
      done              <= (state == ST_FINISH);
      icap.icap_clk     <= (state_n == ST_STROBE);
      icap.icap_ce_n    <= !drive_c;
      icap.icap_write_n <= !drive_c;
      icap.icap_i       <= drive_c ? icap_swap(word_c) : 16'h0000;
    end
  end

endmodule
